mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port synchronous data memory (16-bit words, 2048 deep). It shares the memory between the processor datapath (CPU port) and the UART debug/loader unit (DBG port). The CPU port has priority, and a starvation guard bounds how long DBG can wait. It issues one access at a time through a fixed 4-cycle handshake and returns read data and an acknowledge to the winning requester.

---
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU and DBG request/ack ports, memory bus and busy; slave = arbiter side, master = environment side
interface mem_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 11
);
  logic              cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_ack;
  logic [ADDR_W-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_wdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata, mem_rdata;
  logic              busy;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU-priority arbiter with DBG starvation guard, one 4-cycle memory access at a time; ports clk, reset (async high), bus (mem_arbiter_if.slave)
module mem_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2048,
  parameter int ADDR_W = 11,
  parameter int MAX_WAIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state;
  logic [CW-1:0]     wait_cnt;
  logic              owner, we, dbg_win, sel_we, sel_ok, addr_ok;
  logic [ADDR_W-1:0] addr, sel_addr;
  logic [WIDTH-1:0]  wdata, sel_wdata;
  always_comb begin
    dbg_win = bus.dbg_req && (wait_cnt == CW'(MAX_WAIT) || !bus.cpu_req);
    sel_we = dbg_win ? bus.dbg_we : bus.cpu_we;
    sel_addr = dbg_win ? bus.dbg_addr : bus.cpu_addr;
    sel_wdata = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
    sel_ok = {1'b0, sel_addr} < LIMIT;
    addr_ok = {1'b0, addr} < LIMIT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      owner <= 1'b0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.busy <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.cpu_req || bus.dbg_req) begin
          state <= ISSUE;
          bus.busy <= 1'b1;
          owner <= dbg_win;
          we <= sel_we;
          addr <= sel_addr;
          wdata <= sel_wdata;
          // a CPU grant over a waiting DBG can only happen below MAX_WAIT, so +1 saturates naturally
          wait_cnt <= (!bus.dbg_req || dbg_win) ? '0 : wait_cnt + 1'b1;
          bus.mem_en <= sel_ok;
          bus.mem_we <= sel_ok && sel_we;
          bus.mem_addr <= sel_addr;
          bus.mem_wdata <= sel_wdata;
        end
        ISSUE: begin
          state <= WAIT;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.mem_addr <= '0;
          bus.mem_wdata <= '0;
        end
        WAIT: begin
          state <= RESP;
          if (!we && !owner) bus.cpu_rdata <= addr_ok ? bus.mem_rdata : '0;
          if (!we && owner) bus.dbg_rdata <= addr_ok ? bus.mem_rdata : '0;
          bus.cpu_ack <= !owner;
          bus.dbg_ack <= owner;
        end
        RESP: begin
          state <= IDLE;
          bus.cpu_ack <= 1'b0;
          bus.dbg_ack <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and scoreboard checks of mem_arbiter against a behavioural memory
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.WIDTH(16), .ADDR_W(11)) bus ();
  mem_arbiter #(.WIDTH(16), .DEPTH(2000), .ADDR_W(11), .MAX_WAIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic port; logic we; logic [15:0] rdata; int ack_cyc;} exp_t;
  typedef struct {logic port; logic we; logic [10:0] addr; logic [15:0] wdata; logic [15:0] rdata; int en;} vec_t;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cnt = 0;
  logic [15:0] mem [0:2047];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.cpu_ack, bus.dbg_ack, bus.cpu_rdata, bus.dbg_rdata, bus.mem_en, bus.mem_we,
            bus.mem_addr, bus.mem_wdata, bus.busy};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 16'h0;
  end

  always @(negedge clk) begin
    if (bus.mem_en) en_cnt <= en_cnt + 1;
    if (bus.cpu_ack || bus.dbg_ack) begin
      if (sb.size() == 0) check("spurious_ack", {bus.cpu_ack, bus.dbg_ack}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {bus.cpu_ack, bus.dbg_ack}, e.port ? 2'b01 : 2'b10);
        check("ack_cycle", cyc, e.ack_cyc);
        if (!e.we) check(e.port ? "dbg_rdata" : "cpu_rdata", e.port ? bus.dbg_rdata : bus.cpu_rdata, e.rdata);
      end
    end
  end

  task automatic drive(input logic port, input logic req, input logic we, input logic [10:0] addr, input logic [15:0] wdata);
    if (port) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  task automatic wait_ack(input logic port, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? bus.dbg_ack : bus.cpu_ack) && n < limit);
    if (!(port ? bus.dbg_ack : bus.cpu_ack)) check(port ? "dbg_ack_timeout" : "cpu_ack_timeout", port ? bus.dbg_ack : bus.cpu_ack, 1);
  endtask

  task automatic access(input vec_t v);
    int en0;
    @(negedge clk);
    en0 = en_cnt;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    sb.push_back('{v.port, v.we, v.rdata, cyc + 3});
    wait_ack(v.port, 10);
    drive(v.port, 1'b0, 1'b0, 11'h0, 16'h0);
    check("mem_en_pulses", en_cnt - en0, v.en);
  endtask

  task automatic simul();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 11'h005, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 11'h100, 16'h0);
    sb.push_back('{1'b0, 1'b0, 16'hBEEF, cyc + 3});
    sb.push_back('{1'b1, 1'b0, 16'h1234, cyc + 7});
    wait_ack(1'b0, 10);
    drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
    wait_ack(1'b1, 10);
    drive(1'b1, 1'b0, 1'b0, 11'h0, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [11];
    vec_t rv;
    logic [10:0] caddr [5];
    logic [15:0] cexp [5];
    int c, k, low;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 11'h0, 16'h0);
    vt[0]  = '{1'b0, 1'b1, 11'h005, 16'hBEEF, 16'h0,    1};
    vt[1]  = '{1'b0, 1'b0, 11'h005, 16'h0,    16'hBEEF, 1};
    vt[2]  = '{1'b1, 1'b1, 11'h100, 16'h1234, 16'h0,    1};
    vt[3]  = '{1'b1, 1'b0, 11'h100, 16'h0,    16'h1234, 1};
    vt[4]  = '{1'b0, 1'b0, 11'h100, 16'h0,    16'h1234, 1};
    vt[5]  = '{1'b1, 1'b0, 11'd2047, 16'h0,   16'h0,    0};
    vt[6]  = '{1'b0, 1'b1, 11'd1999, 16'h5A5A, 16'h0,   1};
    vt[7]  = '{1'b0, 1'b0, 11'd1999, 16'h0,   16'h5A5A, 1};
    vt[8]  = '{1'b0, 1'b1, 11'd2040, 16'hAAAA, 16'h0,   0};
    vt[9]  = '{1'b0, 1'b0, 11'd2040, 16'h0,   16'h0,    0};
    vt[10] = '{1'b1, 1'b0, 11'h005, 16'h0,    16'hBEEF, 1};
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 0);
    drive(1'b0, 1'b1, 1'b1, 11'h010, 16'h1111);
    @(negedge clk);
    check("issue_mem_en", {bus.mem_en, bus.mem_we, bus.busy}, 3'b111);
    reset = 1'b1;
    #1;
    check("reset_mid_issue", outs(), 0);
    drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
    @(negedge clk);
    check("reset_held", outs(), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_reset", bus.busy, 0);
    for (int i = 0; i < 11; i++) access(vt[i]);
    check("oor_write_mem", mem[2040], 0);
    check("inrange_write_mem", mem[1999], 16'h5A5A);
    @(negedge clk);
    c = cyc;
    k = 0;
    low = 0;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 1'b1, 16'h0, c + 3 + 4 * i});
    drive(1'b0, 1'b1, 1'b1, 11'h020, 16'hC000);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (!bus.busy) low++;
      if (bus.cpu_ack) begin
        k++;
        if (k == 3) drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        else drive(1'b0, 1'b1, 1'b1, 11'h020 + 11'(k), 16'hC000 + 16'(k));
      end
    end
    check("held_acks", k, 3);
    check("held_idle_cycles", low, 2);
    rv = '{1'b0, 1'b0, 11'h021, 16'h0, 16'hC001, 1};
    access(rv);
    simul();
    caddr[0] = 11'h005; cexp[0] = 16'hBEEF;
    caddr[1] = 11'h100; cexp[1] = 16'h1234;
    caddr[2] = 11'd1999; cexp[2] = 16'h5A5A;
    caddr[3] = 11'h020; cexp[3] = 16'hC000;
    caddr[4] = 11'h022; cexp[4] = 16'hC002;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 1'b0, cexp[i], c + 3 + 4 * i});
    sb.push_back('{1'b1, 1'b0, 16'hBEEF, c + 19});
    sb.push_back('{1'b0, 1'b0, cexp[4], c + 23});
    drive(1'b1, 1'b1, 1'b0, 11'h005, 16'h0);
    drive(1'b0, 1'b1, 1'b0, caddr[0], 16'h0);
    k = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (bus.dbg_ack) drive(1'b1, 1'b0, 1'b0, 11'h0, 16'h0);
      if (bus.cpu_ack) begin
        k++;
        if (k == 5) drive(1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        else drive(1'b0, 1'b1, 1'b0, caddr[k], 16'h0);
      end
    end
    check("starve_cpu_acks", k, 5);
    simul();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("final_idle", bus.busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
